// File: rtl/alu_decode_stage_if.sv
// Handshake bundle between the upstream issue logic, the ALU decode
// stage and the execute ALU.
interface alu_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    modport slave (
        input  in_valid,
        input  in_instr,
        input  in_rs1_val,
        input  in_rs2_val,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_a,
        output out_b,
        output out_alu_ctrl,
        output out_rd,
        output out_we,
        output out_illegal
    );

    modport master (
        output in_valid,
        output in_instr,
        output in_rs1_val,
        output in_rs2_val,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_a,
        input  out_b,
        input  out_alu_ctrl,
        input  out_rd,
        input  out_we,
        input  out_illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32 R/I-type decode into ALU op code, registered behind a skid buffer.
// Build macro ALU_DECODE_LUI_EN makes LUI legal (decoded as 0 + imm).
module alu_decode_stage #(
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic               clk,
    input  logic               rst,
    alu_decode_stage_if.slave  bus
);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SKID
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } dec_t;

    state_t r_state;
    state_t w_next;
    dec_t   r_out;
    dec_t   r_skid;
    dec_t   w_dec;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_shamt;
    logic [31:0] w_imm_u;
    logic        w_ok;
    logic [3:0]  w_ctrl;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_acc;
    logic        w_drn;
    logic        w_ld_out;
    logic        w_ld_skid;
    logic        w_skid2out;
    logic        w_unused;

    assign w_opc   = bus.in_instr[6:0];
    assign w_f3    = bus.in_instr[14:12];
    assign w_f7    = bus.in_instr[31:25];
    assign w_rd    = bus.in_instr[11:7];
    assign w_imm_i = {{20{bus.in_instr[31]}},
                      bus.in_instr[31:20]};
    assign w_shamt = {27'b0, bus.in_instr[24:20]};
    assign w_imm_u = {bus.in_instr[31:12], 12'b0};
    assign w_unused = ^bus.in_instr[19:15];

    always_comb begin
        w_ok   = 1'b0;
        w_ctrl = ALU_ADD;
        w_a    = bus.in_rs1_val;
        w_b    = bus.in_rs2_val;
        case (w_opc)
            OPC_R: begin
                w_ok = 1'b1;
                case ({w_f7, w_f3})
                    {7'h00, 3'b000}: w_ctrl = ALU_ADD;
                    {7'h20, 3'b000}: w_ctrl = ALU_SUB;
                    {7'h00, 3'b111}: w_ctrl = ALU_AND;
                    {7'h00, 3'b110}: w_ctrl = ALU_OR;
                    {7'h00, 3'b100}: w_ctrl = ALU_XOR;
                    {7'h00, 3'b001}: w_ctrl = ALU_SLL;
                    {7'h00, 3'b101}: w_ctrl = ALU_SRL;
                    default:         w_ok   = 1'b0;
                endcase
            end
            OPC_I: begin
                w_ok = 1'b1;
                w_b  = w_imm_i;
                case (w_f3)
                    3'b000: w_ctrl = ALU_ADD;
                    3'b111: w_ctrl = ALU_AND;
                    3'b110: w_ctrl = ALU_OR;
                    3'b100: w_ctrl = ALU_XOR;
                    3'b001: begin
                        w_ctrl = ALU_SLL;
                        w_b    = w_shamt;
                        w_ok   = (w_f7 == 7'h00);
                    end
                    3'b101: begin
                        w_ctrl = ALU_SRL;
                        w_b    = w_shamt;
                        w_ok   = (w_f7 == 7'h00);
                    end
                    default: w_ok = 1'b0;
                endcase
            end
`ifdef ALU_DECODE_LUI_EN
            OPC_LUI: begin
                w_ok   = 1'b1;
                w_ctrl = ALU_ADD;
                w_a    = '0;
                w_b    = w_imm_u;
            end
`endif
            default: w_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_dec.a    = w_a;
        w_dec.b    = w_b;
        w_dec.ctrl = w_ctrl;
        w_dec.rd   = w_rd;
        w_dec.we   = (w_rd != 5'd0);
        w_dec.ill  = 1'b0;
        // Illegal ops must never write back or leak operands.
        if (!w_ok) begin
            w_dec.a    = '0;
            w_dec.b    = '0;
            w_dec.ctrl = ILLEGAL_CTRL;
            w_dec.we   = 1'b0;
            w_dec.ill  = 1'b1;
        end
    end

    assign bus.in_ready  = (r_state != SKID) & ~rst;
    assign bus.out_valid = (r_state != EMPTY);

    assign w_acc = bus.in_valid & bus.in_ready;
    assign w_drn = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_ld_out   = 1'b0;
        w_ld_skid  = 1'b0;
        w_skid2out = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_ld_out = 1'b1;
                    w_next   = FULL;
                end
            end
            FULL: begin
                if (w_acc && w_drn) begin
                    w_ld_out = 1'b1;
                end else if (w_acc) begin
                    w_ld_skid = 1'b1;
                    w_next    = SKID;
                end else if (w_drn) begin
                    w_next = EMPTY;
                end
            end
            SKID: begin
                if (w_drn) begin
                    w_skid2out = 1'b1;
                    w_next     = FULL;
                end
            end
            default: w_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_out)        r_out <= w_dec;
            else if (w_skid2out) r_out <= r_skid;
            if (w_ld_skid)       r_skid <= w_dec;
        end
    end

    assign bus.out_a        = r_out.a;
    assign bus.out_b        = r_out.b;
    assign bus.out_alu_ctrl = r_out.ctrl;
    assign bus.out_rd       = r_out.rd;
    assign bus.out_we       = r_out.we;
    assign bus.out_illegal  = r_out.ill;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed cases plus random stream
// compared against a two-deep FIFO reference model.
module tb_alu_decode_stage;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_decode_stage_if dif();

    alu_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t prev;
    logic hold = 1'b0;
    logic acc;
    logic drn;

    // Decode table indexed by funct3; -1 marks no ALU op.
    function automatic exp_t ref_dec(
        input logic [31:0] ins,
        input logic [31:0] rs1,
        input logic [31:0] rs2
    );
        int tbl[8] = '{0, 5, -1, -1, 4, 6, 3, 2};
        int code;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        exp_t e;
        code = -1;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        a    = rs1;
        b    = 32'h0;
        if (opc == 7'b0110011) begin
            b = rs2;
            if (f7 == 7'h00) code = tbl[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b = {27'h0, ins[24:20]};
                if (f7 == 7'h00) code = tbl[f3];
            end else begin
                b = {{20{ins[31]}}, ins[31:20]};
                code = tbl[f3];
            end
        end
`ifdef ALU_DECODE_LUI_EN
        else if (opc == 7'b0110111) begin
            a    = 32'h0;
            b    = {ins[31:12], 12'h000};
            code = 0;
        end
`endif
        if (code < 0) begin
            e = {32'h0, 32'h0, 4'hF, ins[11:7], 1'b0, 1'b1};
        end else begin
            e = {a, b, code[3:0], ins[11:7],
                 ins[11:7] != 5'd0, 1'b0};
        end
        return e;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [95:0] o,
        input logic [95:0] e
    );
        checks++;
        assert (o === e) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, o, e);
            $error("check %s differs", tag);
        end
    endtask

    task automatic drive(
        input logic        v,
        input logic [31:0] ins,
        input logic [31:0] r1,
        input logic [31:0] r2,
        input logic        ordy
    );
        dif.in_valid   = v;
        dif.in_instr   = ins;
        dif.in_rs1_val = r1;
        dif.in_rs2_val = r2;
        dif.out_ready  = ordy;
    endtask

    function automatic exp_t obs_now();
        return {dif.out_a, dif.out_b, dif.out_alu_ctrl,
                dif.out_rd, dif.out_we, dif.out_illegal};
    endfunction

    // One clock: check, predict the edge, advance to next negedge.
    task automatic cycle();
        exp_t obs;
        exp_t nxt;
        #1;
        obs = obs_now();
        chk("in_ready", 96'(dif.in_ready),
            96'(!rst && q.size() < 2));
        chk("out_valid", 96'(dif.out_valid),
            96'(q.size() != 0));
        if (hold) chk("hold", 96'(obs), 96'(prev));
        if (q.size() != 0 && dif.out_valid)
            chk("data", 96'(obs), 96'(q[0]));
        acc  = dif.in_valid & dif.in_ready;
        drn  = dif.out_valid & dif.out_ready;
        hold = dif.out_valid & !dif.out_ready & !rst;
        prev = obs;
        nxt  = ref_dec(dif.in_instr, dif.in_rs1_val,
                       dif.in_rs2_val);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (drn && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(nxt);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        logic [6:0]  f7;
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       opc = 7'b0110011;
            1:       opc = 7'b0010011;
            2:       opc = 7'b0110111;
            default: opc = r[31:25];
        endcase
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = r[6:0];
        endcase
        return {f7, r[24:15], r[14:12], r[11:7], opc};
    endfunction

    logic [31:0] burst[4];
    int idx;
    int ndr;

    initial begin
        rst = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_outs", 96'(obs_now()), 96'h0);
        rst = 1'b0;

        cycle();
        chk("add_valid", 96'(dif.out_valid), 96'h1);
        chk("add_ctrl", 96'(dif.out_alu_ctrl), 96'h0);
        chk("add_a", 96'(dif.out_a), 96'd5);
        chk("add_b", 96'(dif.out_b), 96'd7);
        chk("add_rd", 96'(dif.out_rd), 96'd3);
        chk("add_we", 96'(dif.out_we), 96'h1);

        drive(1'b1, 32'h402081B3, 32'd9, 32'd4, 1'b1);
        cycle();
        chk("sub_ctrl", 96'(dif.out_alu_ctrl), 96'h1);

        drive(1'b1, 32'hFFF00093, 32'd123, 32'd0, 1'b1);
        cycle();
        chk("addi_b", 96'(dif.out_b), 96'hFFFFFFFF);
        chk("addi_ctrl", 96'(dif.out_alu_ctrl), 96'h0);

        drive(1'b1, 32'h01F0D093, 32'h80000000, 32'd0, 1'b1);
        cycle();
        chk("srli_b", 96'(dif.out_b), 96'd31);
        chk("srli_ctrl", 96'(dif.out_alu_ctrl), 96'h6);

        drive(1'b1, 32'h41F0D093, 32'h80000000, 32'd0, 1'b1);
        cycle();
        chk("srai_ill", 96'(dif.out_illegal), 96'h1);
        chk("srai_ctrl", 96'(dif.out_alu_ctrl), 96'hF);
        chk("srai_we", 96'(dif.out_we), 96'h0);

        drive(1'b1, 32'h00208033, 32'd1, 32'd2, 1'b1);
        cycle();
        chk("x0_we", 96'(dif.out_we), 96'h0);
        chk("x0_ill", 96'(dif.out_illegal), 96'h0);

        drive(1'b1, 32'h123450B7, 32'hDEAD, 32'hBEEF, 1'b1);
        cycle();
`ifdef ALU_DECODE_LUI_EN
        chk("lui_a", 96'(dif.out_a), 96'h0);
        chk("lui_b", 96'(dif.out_b), 96'h12345000);
        chk("lui_ctrl", 96'(dif.out_alu_ctrl), 96'h0);
`else
        chk("lui_ill", 96'(dif.out_illegal), 96'h1);
`endif

        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        cycle();
        cycle();

        burst[0] = 32'h002081B3;
        burst[1] = 32'h0050E133;
        burst[2] = 32'h00F1F193;
        burst[3] = 32'h00311213;
        idx = 0;
        ndr = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx >= 4 && q.size() == 0) break;
            drive(idx < 4, burst[idx < 4 ? idx : 0],
                  32'(100 + c), 32'(200 + c), c >= 3);
            cycle();
            if (acc) idx++;
            if (drn) ndr++;
            if (c == 1) chk("skid_rdy", 96'(dif.in_ready), 96'h0);
        end
        chk("burst_in", 96'(idx), 96'd4);
        chk("burst_out", 96'(ndr), 96'd4);

        for (int i = 0; i < 300; i++) begin
            rst = (i == 150);
            drive($urandom_range(0, 3) != 0, rnd_instr(),
                  $urandom(), $urandom(),
                  $urandom_range(0, 2) != 0);
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle();
        chk("drained", 96'(q.size()), 96'h0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
